// File: rtl/lneg_seq.sv
// lneg_seq: multi-cycle logical negation !(|vin), OR-reducing one CHUNK per cycle, MSB chunk first
module lneg_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   parameter bit EARLY = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] vin,
   output logic             busy,
   output logic             done,
   output logic             vout
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             acc, acc_nx, last;
   assign busy = state != IDLE;
   always_comb begin
      acc_nx   = acc | (|sreg[WIDTH-1 -: CHUNK]);
      last     = (cnt == CW'(N - 1)) || (EARLY && acc_nx);
      state_nx = state == IDLE ? (start ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sreg  <= '0;
         acc   <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
         vout  <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= state == RUN && last;
         if (state == IDLE && start) begin
            sreg <= vin;
            acc  <= 1'b0;
            cnt  <= '0;
         end else if (state == RUN) begin
            acc  <= acc_nx;
            sreg <= sreg << CHUNK;
            cnt  <= cnt + 1'b1;
            if (last) vout <= ~acc_nx;
         end
      end
   end
endmodule

// File: tb/tb_lneg_seq.sv
// tb_lneg_seq: checks six lneg_seq variants (CHUNK 1/4/16 x EARLY 0/1) against a latency/result model
module tb_lneg_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  start = '0;
   logic [15:0] vin = '0;
   logic [5:0]  busy, done, vout;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 6; g++) begin : dut
      lneg_seq #(
         .WIDTH(16),
         .CHUNK((g < 2) ? 1 : (g < 4) ? 4 : 16),
         .EARLY(g % 2 == 1)
      ) u (
         .clk(clk),
         .rst_n(rst_n),
         .start(start[g]),
         .vin(vin),
         .busy(busy[g]),
         .done(done[g]),
         .vout(vout[g])
      );
   end

   function automatic int chunk_of(int i);
      return (i < 2) ? 1 : (i < 4) ? 4 : 16;
   endfunction

   // Edges from accept to done: first nonzero chunk from the MSB when early exit is on
   function automatic int exp_lat(int c, int e, logic [15:0] v);
      int n = 16 / c;
      logic [15:0] s;
      if (e == 0) return n;
      for (int i = 0; i < n; i++) begin
         s = v << (i * c);
         s = s >> (16 - c);
         if (s != 0) return i + 1;
      end
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   // Accept v on every instance in m, then watch 20 edges while scrambling vin
   task automatic run_op(input logic [5:0] m, input logic [15:0] v);
      int dcnt[6], bcnt[6], lat[6];
      logic res[6];
      vin = v;
      start = m;
      tick();
      start = '0;
      for (int i = 0; i < 6; i++) begin
         dcnt[i] = 0; bcnt[i] = 0; lat[i] = -1; res[i] = 1'bx;
      end
      for (int t = 1; t <= 20; t++) begin
         for (int i = 0; i < 6; i++) if (busy[i]) bcnt[i]++;
         vin = 16'($urandom);
         tick();
         for (int i = 0; i < 6; i++) if (done[i]) begin
            dcnt[i]++;
            lat[i] = t;
            res[i] = vout[i];
         end
      end
      for (int i = 0; i < 6; i++) if (m[i]) begin
         chk("done_count", i, dcnt[i], 1);
         chk("latency", i, lat[i], exp_lat(chunk_of(i), i % 2, v));
         chk("busy_cycles", i, bcnt[i], exp_lat(chunk_of(i), i % 2, v) + 1);
         chk("vout", i, {31'd0, res[i]}, {31'd0, v == 16'h0});
         chk("vout_hold", i, {31'd0, vout[i]}, {31'd0, v == 16'h0});
         chk("idle_after", i, {31'd0, busy[i]}, 0);
      end
   endtask

   initial begin
      logic [5:0] seen;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_busy", 0, busy, 0);
      chk("rst_done", 0, done, 0);
      chk("rst_vout", 0, vout, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 0, busy, 0);

      run_op('1, 16'h0000);
      run_op('1, 16'h8000);
      run_op('1, 16'h0001);
      run_op('1, 16'h0100);
      run_op('1, 16'hFFFF);

      // start during RUN and DONE of dut3 must be ignored
      run_op('1, 16'h0000);
      vin = 16'h0000;
      start[3] = 1'b1;
      tick();
      vin = 16'hFFFF;
      for (int t = 1; t <= 3; t++) begin
         tick();
         chk("ign_run_busy", 3, {31'd0, busy[3]}, 1);
         chk("ign_run_done", 3, {31'd0, done[3]}, 0);
      end
      tick();
      chk("ign_done", 3, {31'd0, done[3]}, 1);
      chk("ign_vout", 3, {31'd0, vout[3]}, 1);
      tick();
      chk("ign_idle_busy", 3, {31'd0, busy[3]}, 0);
      chk("ign_idle_done", 3, {31'd0, done[3]}, 0);
      tick();
      start[3] = 1'b0;
      chk("reacc_busy", 3, {31'd0, busy[3]}, 1);
      tick();
      chk("reacc_done", 3, {31'd0, done[3]}, 1);
      chk("reacc_vout", 3, {31'd0, vout[3]}, 0);
      tick();

      // reset during RUN aborts without a done pulse
      run_op('1, 16'h0000);
      vin = 16'h0000;
      start = '1;
      tick();
      start = '0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", 0, busy, 0);
      chk("abort_done", 0, done, 0);
      chk("abort_vout", 0, vout, 0);
      seen = '0;
      for (int t = 0; t < 20; t++) begin
         tick();
         seen |= done | busy;
      end
      chk("abort_quiet", 0, seen, 0);
      run_op('1, 16'h0000);
      run_op('1, 16'h0010);

      for (int r = 0; r < 1000; r++) run_op('1, 16'($urandom) >> $urandom_range(0, 16));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
